// File: rtl/ram_sincrona_dp_if.sv
// Write/read port bundle for ram_sincrona_dp.
// The master side drives requests; the slave side (the RAM) returns data and status.
interface ram_sincrona_dp_if #(
  parameter int ANCHO     = 8,
  parameter int ANCHO_DIR = 8
);
  logic                 we;
  logic [ANCHO_DIR-1:0] dir_e;
  logic [ANCHO-1:0]     dato_e;
  logic                 re;
  logic [ANCHO_DIR-1:0] dir_s;
  logic [ANCHO-1:0]     dato_s;
  logic                 valido_s;
  logic                 ocupado;
  logic                 error_dir;

  modport master (
    output we, dir_e, dato_e, re, dir_s,
    input  dato_s, valido_s, ocupado, error_dir
  );

  modport slave (
    input  we, dir_e, dato_e, re, dir_s,
    output dato_s, valido_s, ocupado, error_dir
  );
endinterface

// File: rtl/ram_sincrona_dp.sv
// Synchronous RAM with one write port, one read port and a post-reset clear sweep.
// Optional macro RAM_SALIDA_REG_EN adds a second read output stage (latency 2).
module ram_sincrona_dp #(
  parameter int              ANCHO       = 8,
  parameter int              PROFUNDIDAD = 11,
  parameter int              ANCHO_DIR   = 8,
  parameter logic [ANCHO-1:0] VALOR_INIT = '0
) (
  input logic               clk,
  input logic               rst,
  ram_sincrona_dp_if.slave  bus
);

  localparam int unsigned IW = (PROFUNDIDAD > 1) ? $clog2(PROFUNDIDAD) : 1;
  localparam logic [ANCHO_DIR:0]   PROF_L = (ANCHO_DIR+1)'(PROFUNDIDAD);
  localparam logic [ANCHO_DIR-1:0] ULTIMA = ANCHO_DIR'(PROFUNDIDAD - 1);

  typedef enum logic {LIMPIANDO, LISTO} estado_t;

  estado_t              estado, estado_sig;
  logic [ANCHO_DIR-1:0] ptr;
  logic [ANCHO-1:0]     mem [PROFUNDIDAD];

  logic limpiando, fin_limpieza;
  logic dir_e_mala, dir_s_mala, esc_ok, lec_ok;

  logic [ANCHO-1:0] dato_r1;
  logic             valido_r1;
  logic             error_r;

  assign dir_e_mala = ({1'b0, bus.dir_e} >= PROF_L);
  assign dir_s_mala = ({1'b0, bus.dir_s} >= PROF_L);
  assign esc_ok     = !limpiando && bus.we && !dir_e_mala;
  assign lec_ok     = !limpiando && bus.re && !dir_s_mala;

  always_comb begin
    estado_sig   = estado;
    limpiando    = (estado == LIMPIANDO);
    fin_limpieza = 1'b0;
    if (estado == LIMPIANDO && ptr == ULTIMA) begin
      fin_limpieza = 1'b1;
      estado_sig   = LISTO;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado <= LIMPIANDO;
      ptr    <= '0;
    end else begin
      estado <= estado_sig;
      if (limpiando && !fin_limpieza)
        ptr <= ptr + ANCHO_DIR'(1);
    end
  end

  // Memory has no reset: words survive rst until the sweep reaches them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (limpiando)
        mem[ptr[IW-1:0]] <= VALOR_INIT;
      else if (esc_ok)
        mem[bus.dir_e[IW-1:0]] <= bus.dato_e;
    end
  end

  // Nonblocking read of mem gives read-first behaviour on same-address collisions.
  always_ff @(posedge clk) begin
    if (rst) begin
      dato_r1   <= '0;
      valido_r1 <= 1'b0;
      error_r   <= 1'b0;
    end else begin
      valido_r1 <= lec_ok;
      if (lec_ok)
        dato_r1 <= mem[bus.dir_s[IW-1:0]];
      error_r <= !limpiando && ((bus.we && dir_e_mala) || (bus.re && dir_s_mala));
    end
  end

`ifdef RAM_SALIDA_REG_EN
  logic [ANCHO-1:0] dato_r2;
  logic             valido_r2;

  always_ff @(posedge clk) begin
    if (rst) begin
      dato_r2   <= '0;
      valido_r2 <= 1'b0;
    end else begin
      dato_r2   <= dato_r1;
      valido_r2 <= valido_r1;
    end
  end

  assign bus.dato_s   = dato_r2;
  assign bus.valido_s = valido_r2;
`else
  assign bus.dato_s   = dato_r1;
  assign bus.valido_s = valido_r1;
`endif

  assign bus.ocupado   = limpiando;
  assign bus.error_dir = error_r;

endmodule
